// File: rtl/mem_bus_adapter_if.sv
// Request/return and Wishbone-classic signal bundle for mem_bus_adapter.
// slave = adapter view, master = requester plus bus-responder view.
interface mem_bus_adapter_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        bus_full;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  modport slave (
    input  req_read, req_write, req_addr,
    input  req_wdata, req_sel,
    input  wb_dat_i, wb_ack,
    output bus_full, rdata, rvalid, err,
    output wb_cyc, wb_stb, wb_we,
    output wb_adr, wb_dat_o, wb_sel
  );

  modport master (
    output req_read, req_write, req_addr,
    output req_wdata, req_sel,
    output wb_dat_i, wb_ack,
    input  bus_full, rdata, rvalid, err,
    input  wb_cyc, wb_stb, wb_we,
    input  wb_adr, wb_dat_o, wb_sel
  );
endinterface

// File: rtl/mem_bus_adapter.sv
// Buffers single-word requests in a small FIFO and replays each one
// as a Wishbone-classic cycle with ack timeout and read-data return.
module mem_bus_adapter #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mem_bus_adapter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } entry_t;

  typedef enum logic {IDLE, BUSY} state_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  entry_t         in_e;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic [15:0]    tcnt;
  state_t         state;
  logic           full;
  logic           push;
  logic           pop;

  assign full = (count == CW'(DEPTH));
  assign bus.bus_full = full;
  assign push = (bus.req_read | bus.req_write) & ~full;
  assign pop = (state == BUSY) &
               (bus.wb_ack | (tcnt == TLAST));
  assign head = mem[rptr];
  assign in_e = {bus.req_write, bus.req_addr,
                 bus.req_wdata, bus.req_sel};

  // FIFO storage; validity is tracked by count, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_e;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus FSM: issue head entry, wait for ack or timeout, return data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tcnt         <= '0;
      bus.wb_cyc   <= 1'b0;
      bus.wb_stb   <= 1'b0;
      bus.wb_we    <= 1'b0;
      bus.wb_adr   <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_sel   <= '0;
      bus.rdata    <= '0;
      bus.rvalid   <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            bus.wb_adr   <= head.addr;
            bus.wb_dat_o <= head.wdata;
            bus.wb_sel   <= head.sel;
            bus.wb_we    <= head.we;
            bus.wb_cyc   <= 1'b1;
            bus.wb_stb   <= 1'b1;
            tcnt         <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (bus.wb_ack) begin
            bus.wb_cyc <= 1'b0;
            bus.wb_stb <= 1'b0;
            state      <= IDLE;
            if (!bus.wb_we) begin
              bus.rdata  <= bus.wb_dat_i;
              bus.rvalid <= 1'b1;
            end
          end else if (tcnt == TLAST) begin
            bus.wb_cyc <= 1'b0;
            bus.wb_stb <= 1'b0;
            bus.err    <= 1'b1;
            state      <= IDLE;
            if (!bus.wb_we) begin
              bus.rdata  <= 32'hDEAD_BEEF;
              bus.rvalid <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Bench for mem_bus_adapter: transaction-level queue model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_adapter;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_bus_adapter_if bus ();

  mem_bus_adapter #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } txn_t;

  txn_t        q[$];
  txn_t        t;
  bit          m_busy;
  int          m_cycles;
  logic        m_rvalid;
  logic        m_err;
  logic [31:0] m_rdata;
  bit          was_full;
  bit          start;
  bit          done;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          ack_en;
  logic [31:0] rd_val;

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // bus responder: ack one cycle after cyc is seen, if enabled
  always @(negedge clk) begin
    bus.wb_ack   = ack_en && (bus.wb_cyc === 1'b1);
    bus.wb_dat_i = rd_val;
  end

  // reference model step at each edge, then compare shortly after
  always begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_busy   = 0;
      m_cycles = 0;
      m_rvalid = 0;
      m_err    = 0;
      m_rdata  = '0;
    end else begin
      was_full = (q.size() == DEPTH);
      m_rvalid = 0;
      m_err    = 0;
      done     = 0;
      start    = 0;
      if (m_busy) begin
        m_cycles++;
        if (bus.wb_ack) begin
          done = 1;
          if (!q[0].we) begin
            m_rvalid = 1;
            m_rdata  = bus.wb_dat_i;
          end
        end else if (m_cycles == TIMEOUT) begin
          done  = 1;
          m_err = 1;
          if (!q[0].we) begin
            m_rvalid = 1;
            m_rdata  = 32'hDEAD_BEEF;
          end
        end
      end else if (q.size() != 0) begin
        start = 1;
      end
      if ((bus.req_read || bus.req_write) && !was_full) begin
        t.we    = bus.req_write;
        t.addr  = bus.req_addr;
        t.wdata = bus.req_wdata;
        t.sel   = bus.req_sel;
        q.push_back(t);
      end
      if (done) begin
        void'(q.pop_front());
        m_busy = 0;
      end
      if (start) begin
        m_busy   = 1;
        m_cycles = 0;
      end
    end
    #1;
    check("bus_full", bus.bus_full, q.size() == DEPTH);
    check("wb_cyc", bus.wb_cyc, m_busy);
    check("wb_stb", bus.wb_stb, m_busy);
    if (m_busy) begin
      check("wb_adr", bus.wb_adr, q[0].addr);
      check("wb_we", bus.wb_we, q[0].we);
      check("wb_dat_o", bus.wb_dat_o, q[0].wdata);
      check("wb_sel", bus.wb_sel, q[0].sel);
    end
    check("rvalid", bus.rvalid, m_rvalid);
    check("err", bus.err, m_err);
    check("rdata", bus.rdata, m_rdata);
  end

  task automatic send(bit rd, bit wr, logic [31:0] a,
                      logic [31:0] d, logic [3:0] s);
    bit ok = 0;
    @(negedge clk);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_sel   = s;
    for (int i = 0; i < 50; i++) begin
      if (!bus.bus_full) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_accept: got none want accept a=%h", a);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int nv;
    int at;
    bus.req_read  = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0040;
    bus.req_wdata = '0;
    bus.req_sel   = 4'hF;
    ack_en        = 1'b1;
    rd_val        = 32'h1234_5678;

    // power-on reset with a read held pending
    repeat (2) @(posedge clk);
    #1;
    check("por_rvalid", bus.rvalid, 0);
    check("por_err", bus.err, 0);
    check("por_cyc", bus.wb_cyc, 0);
    check("por_stb", bus.wb_stb, 0);
    check("por_adr", bus.wb_adr, 0);
    check("por_full", bus.bus_full, 0);
    check("por_rdata", bus.rdata, 0);
    @(negedge clk) rst = 1'b0;

    // single read accepted at the first edge after release
    @(posedge clk);
    idle();
    @(posedge clk);
    #1;
    check("rd_cyc", bus.wb_cyc, 1);
    check("rd_adr", bus.wb_adr, 32'h40);
    check("rd_we", bus.wb_we, 0);
    @(posedge clk);
    #1;
    check("rd_rvalid", bus.rvalid, 1);
    check("rd_rdata", bus.rdata, 32'h1234_5678);
    @(posedge clk);
    #1;
    check("rd_rvalid_once", bus.rvalid, 0);

    // write then read back-to-back
    rd_val = 32'hA5A5_0001;
    send(0, 1, 32'h80, 32'hCAFE_F00D, 4'hF);
    send(1, 0, 32'h80, 32'h0, 4'hF);
    #1;
    check("wr_we", bus.wb_we, 1);
    check("wr_dat", bus.wb_dat_o, 32'hCAFE_F00D);
    check("wr_adr", bus.wb_adr, 32'h80);
    idle();
    nv = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rvalid) nv++;
    end
    check("wr_rd_nvalid", nv, 1);
    check("wr_rd_rdata", bus.rdata, 32'hA5A5_0001);

    // fill the FIFO while the bus stalls
    ack_en = 1'b0;
    rd_val = 32'h0BAD_0300;
    send(1, 0, 32'h300, 32'h0, 4'h1);
    send(1, 0, 32'h304, 32'h0, 4'h2);
    #1;
    check("full_set", bus.bus_full, 1);
    ack_en = 1'b1;
    send(1, 0, 32'h308, 32'h0, 4'h4);
    #1;
    check("full_next_cyc", bus.wb_cyc, 1);
    check("full_next_adr", bus.wb_adr, 32'h304);
    idle();
    repeat (15) @(posedge clk);
    #1;

    // ack never arrives: timeout abort on a read
    ack_en = 1'b0;
    send(1, 0, 32'h100, 32'h0, 4'hF);
    send(1, 0, 32'h104, 32'h0, 4'hF);
    idle();
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.err) begin
        at = i;
        break;
      end
    end
    check("to_edge", at, 3);
    check("to_err", bus.err, 1);
    check("to_rvalid", bus.rvalid, 1);
    check("to_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("to_cyc", bus.wb_cyc, 0);
    @(posedge clk);
    #1;
    check("to_next_cyc", bus.wb_cyc, 1);
    check("to_next_adr", bus.wb_adr, 32'h104);
    repeat (8) @(posedge clk);
    #1;

    // reset asserted mid-cycle with two entries queued
    send(1, 0, 32'h200, 32'h0, 4'hF);
    send(1, 0, 32'h204, 32'h0, 4'hF);
    idle();
    check("mr_pre_cyc", bus.wb_cyc, 1);
    check("mr_pre_full", bus.bus_full, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_cyc", bus.wb_cyc, 0);
    check("mr_stb", bus.wb_stb, 0);
    check("mr_full", bus.bus_full, 0);
    @(negedge clk) rst = 1'b0;
    ack_en = 1'b1;
    nv = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.rvalid || bus.err || bus.wb_cyc) nv++;
    end
    check("mr_quiet", nv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
